// File: rtl/score_pkg.sv
// Shared types and constants for the score display: BCD digit type,
// glyph geometry, palette conventions and the accumulator state encoding.
package score_pkg;

    typedef logic [3:0] bcd_t;

    localparam int   DIGIT_W         = 32;
    localparam int   DIGIT_H         = 48;
    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    localparam bcd_t SCORE_MAX_DIGIT = 4'd9;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_ADD  = 1'b1
    } acc_state_t;

    // Points above a single decimal digit are treated as the largest digit.
    function automatic bcd_t clamp_points(input logic [3:0] points);
        return (points > SCORE_MAX_DIGIT) ? SCORE_MAX_DIGIT : points;
    endfunction

endpackage

// File: rtl/score_bcd_accumulator.sv
// Working score: NUM_DIGITS BCD digits (digit 0 is the most significant).
// An accepted add lands in the units digit and the carry then ripples one
// digit per cycle toward digit 0; a carry out of digit 0 pins every digit to 9.
module score_bcd_accumulator
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 6
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    clear,
    input  logic                    add_valid,
    input  logic [3:0]              add_points,
    output logic                    add_ready,
    output logic                    idle,
    output logic [4*NUM_DIGITS-1:0] score
);

    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    acc_state_t       state;
    bcd_t             digits [NUM_DIGITS];
    logic [POS_W-1:0] pos;
    bcd_t             addend;
    logic [4:0]       sum;
    logic             carry;

    assign idle      = (state == ACC_IDLE);
    assign add_ready = idle && !clear;

    // Sum of the digit under the ripple pointer and the pending addend.
    // NOTE: every always_comb output gets a value on every path (here by
    // plain assignment); a path that skips one would infer a latch.
    always_comb begin
        sum   = {1'b0, digits[pos]} + {1'b0, addend};
        carry = (sum > 5'd9);
    end

    // Flatten the digit array for the display latch in the parent.
    always_comb begin
        score = '0;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            score[4*p +: 4] = digits[p];
        end
    end

    // Handshake, clear/abort, carry ripple and saturation.
    // NOTE: state is updated with non-blocking assignments only, so every
    // register here samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state  <= ACC_IDLE;
            pos    <= '0;
            addend <= '0;
            // NOTE: the digit array is architectural state and is reset
            // explicitly; it is a handful of flops, not a RAM.
            for (int p = 0; p < NUM_DIGITS; p++) begin
                digits[p] <= '0;
            end
        end else begin
            case (state)
                ACC_IDLE: begin
                    if (clear) begin
                        for (int p = 0; p < NUM_DIGITS; p++) begin
                            digits[p] <= '0;
                        end
                    end else if (add_valid) begin
                        addend <= clamp_points(add_points);
                        pos    <= POS_W'(NUM_DIGITS - 1);
                        state  <= ACC_ADD;
                    end
                end
                ACC_ADD: begin
                    if (clear) begin
                        for (int p = 0; p < NUM_DIGITS; p++) begin
                            digits[p] <= '0;
                        end
                        state <= ACC_IDLE;
                    end else if (!carry) begin
                        digits[pos] <= sum[3:0];
                        state       <= ACC_IDLE;
                    end else if (pos == '0) begin
                        for (int p = 0; p < NUM_DIGITS; p++) begin
                            digits[p] <= SCORE_MAX_DIGIT;
                        end
                        state <= ACC_IDLE;
                    end else begin
                        digits[pos] <= 4'(sum - 5'd10);
                        pos         <= pos - 1'b1;
                        addend      <= 4'd1;
                    end
                end
                default: state <= ACC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Score display: owns the per-frame shadow copy of the score and the
// three-stage render pipeline that turns the beam position into a glyph ROM
// address and then into a palette index for the digit under the beam.
module score_digit_renderer
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int ORIGIN_X   = 448,
    parameter int ORIGIN_Y   = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic        clear,
    input  logic        add_valid,
    output logic        add_ready,
    input  logic [3:0]  add_points,
    output logic [10:0] rom_read_address,
    input  logic [39:0] rom_data,
    output logic [3:0]  pixel_index,
    output logic        pixel_on
);

    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + DIGIT_W * NUM_DIGITS);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + DIGIT_H);

    logic [4*NUM_DIGITS-1:0] score;
    logic                    idle;
    bcd_t                    shadow [NUM_DIGITS];
    logic                    pending;

    logic                    in_box;
    logic [9:0]              rx;
    logic [5:0]              ry_row;
    logic [POS_W-1:0]        col_pos;
    logic                    hit_s1, hit_s2;
    bcd_t                    digit_s1, digit_s2;
    logic [3:0]              nibble;

    score_bcd_accumulator #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_accumulator (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .clear      (clear),
        .add_valid  (add_valid),
        .add_points (add_points),
        .add_ready  (add_ready),
        .idle       (idle),
        .score      (score)
    );

    // Copy the score for display at frame start, deferred past any add in flight.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pending <= 1'b0;
            for (int p = 0; p < NUM_DIGITS; p++) begin
                shadow[p] <= '0;
            end
        end else if (idle && (frame_start || pending)) begin
            pending <= 1'b0;
            for (int p = 0; p < NUM_DIGITS; p++) begin
                shadow[p] <= score[4*p +: 4];
            end
        end else if (frame_start) begin
            pending <= 1'b1;
        end
    end

    // Beam position relative to the score box and the glyph cell it falls in.
    always_comb begin
        in_box  = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                  ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
        rx      = 10'({1'b0, DrawX} - X_LO);
        ry_row  = 6'({1'b0, DrawY} - Y_LO);
        col_pos = POS_W'(rx[9:5]);
        nibble  = rom_data[{digit_s2, 2'b00} +: 4];
    end

    // Address, ROM-latency alignment and palette select, one stage per edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_read_address <= '0;
            hit_s1           <= 1'b0;
            digit_s1         <= '0;
            hit_s2           <= 1'b0;
            digit_s2         <= '0;
            pixel_index      <= TRANSPARENT_IDX;
            pixel_on         <= 1'b0;
        end else begin
            rom_read_address <= in_box ? {ry_row, rx[4:0]} : 11'd0;
            hit_s1           <= in_box;
            digit_s1         <= in_box ? shadow[col_pos] : 4'd0;
            hit_s2           <= hit_s1;
            digit_s2         <= digit_s1;
            pixel_index      <= hit_s2 ? nibble : TRANSPARENT_IDX;
            pixel_on         <= hit_s2 && (nibble != TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Bench for score_digit_renderer: a six-digit and a three-digit instance share
// all stimulus; a decimal-arithmetic model predicts score, shadow, add latency
// and the pixel stream, while stub glyph ROMs answer each instance's address.
module tb_score_digit_renderer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        frame_start, clear, add_valid;
    logic [3:0]  add_points;
    logic        add_ready0, add_ready1;
    logic [10:0] addr0, addr1;
    logic [39:0] rom0, rom1;
    logic [3:0]  pix0, pix1;
    logic        on0, on1;

    int rom_mode;
    int n_checks = 0;
    int n_pass   = 0;
    int score_m  [2];
    int shadow_m [2];

    always #5 Clk = ~Clk;

    score_digit_renderer #(.NUM_DIGITS(6), .ORIGIN_X(448), .ORIGIN_Y(16)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .clear(clear), .add_valid(add_valid),
        .add_ready(add_ready0), .add_points(add_points),
        .rom_read_address(addr0), .rom_data(rom0),
        .pixel_index(pix0), .pixel_on(on0));

    score_digit_renderer #(.NUM_DIGITS(3), .ORIGIN_X(448), .ORIGIN_Y(16)) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .clear(clear), .add_valid(add_valid),
        .add_ready(add_ready1), .add_points(add_points),
        .rom_read_address(addr1), .rom_data(rom1),
        .pixel_index(pix1), .pixel_on(on1));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int nd_of(input int n);
        return (n == 0) ? 6 : 3;
    endfunction

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r *= 10;
        return r;
    endfunction

    function automatic int max_of(input int n);
        return pow10(nd_of(n)) - 1;
    endfunction

    function automatic int digit_of(input int v, input int pos, input int ndig);
        return (v / pow10(ndig - 1 - pos)) % 10;
    endfunction

    // Cycles spent adding: the units digit, plus one per digit the carry reaches.
    function automatic int add_cycles(input int s, input int p, input int ndig);
        int n;
        if (s % 10 + p < 10) return 1;
        n = 1;
        for (int j = 1; j < ndig; j++) begin
            n++;
            if ((s / pow10(j)) % 10 != 9) break;
        end
        return n;
    endfunction

    // Stub glyph ROMs: mode 0 returns the digit number, mode 1 a hash of digit and address.
    function automatic int rom_nib(input int mode, input int k, input int a);
        if (mode == 0) return k;
        return (k * 5 + a * 3 + a / 32) % 16;
    endfunction

    function automatic logic [39:0] rom_word(input int mode, input int a);
        logic [39:0] w = '0;
        for (int k = 0; k < 10; k++) w[4*k +: 4] = 4'(rom_nib(mode, k, a));
        return w;
    endfunction

    function automatic bit in_box(input int n, input int x, input int y);
        return (x >= 448) && (x < 448 + 32 * nd_of(n)) && (y >= 16) && (y < 64);
    endfunction

    function automatic int exp_addr(input int n, input int x, input int y);
        return in_box(n, x, y) ? (y - 16) * 32 + (x - 448) % 32 : 0;
    endfunction

    function automatic int exp_index(input int n, input int x, input int y);
        if (!in_box(n, x, y)) return 0;
        return rom_nib(rom_mode, digit_of(shadow_m[n], (x - 448) / 32, nd_of(n)),
                       exp_addr(n, x, y));
    endfunction

    always @(posedge Clk) begin
        rom0 <= rom_word(rom_mode, int'(addr0));
        rom1 <= rom_word(rom_mode, int'(addr1));
    end

    // ---------------- stimulus tasks ----------------
    task automatic probe(input int xs[$], input int ys[$]);
        int n = xs.size();
        int ea0[$], ea1[$], ep0[$], ep1[$];
        for (int i = 0; i < n; i++) begin
            ea0.push_back(exp_addr(0, xs[i], ys[i]));
            ea1.push_back(exp_addr(1, xs[i], ys[i]));
            ep0.push_back(exp_index(0, xs[i], ys[i]));
            ep1.push_back(exp_index(1, xs[i], ys[i]));
        end
        for (int i = 0; i < n + 3; i++) begin
            @(negedge Clk);
            if (i >= 1 && i <= n) begin
                check("rom_addr0", addr0, ea0[i-1]);
                check("rom_addr1", addr1, ea1[i-1]);
            end
            if (i >= 3) begin
                check("pixel_index0", pix0, ep0[i-3]);
                check("pixel_on0", on0, int'(ep0[i-3] != 0));
                check("pixel_index1", pix1, ep1[i-3]);
                check("pixel_on1", on1, int'(ep1[i-3] != 0));
            end
            if (i < n) begin
                DrawX = 10'(xs[i]);
                DrawY = 10'(ys[i]);
            end
        end
    endtask

    task automatic stream(input int cycles);
        int xs[$], ys[$];
        for (int i = 0; i < cycles; i++) begin
            xs.push_back(400 + int'($urandom_range(300)));
            ys.push_back(int'($urandom_range(80)));
        end
        probe(xs, ys);
    endtask

    task automatic display();
        int xs[$], ys[$];
        rom_mode = 0;
        for (int p = 0; p < 6; p++) begin
            xs.push_back(448 + 32 * p + int'($urandom_range(31)));
            ys.push_back(16 + int'($urandom_range(47)));
        end
        probe(xs, ys);
    endtask

    task automatic latch();
        @(negedge Clk); frame_start = 1'b1;
        @(negedge Clk); frame_start = 1'b0;
        for (int n = 0; n < 2; n++) shadow_m[n] = score_m[n];
    endtask

    task automatic do_clear();
        @(negedge Clk); clear = 1'b1;
        @(negedge Clk); clear = 1'b0;
        for (int n = 0; n < 2; n++) score_m[n] = 0;
    endtask

    // One add; optionally pulse frame_start or clear fs_at/clr_at cycles after acceptance.
    task automatic do_add(input int p, input int fs_at, input int clr_at);
        int pc = (p > 9) ? 9 : p;
        int exp_cyc [2];
        int got_cyc [2];
        for (int n = 0; n < 2; n++) begin
            exp_cyc[n] = add_cycles(score_m[n], pc, nd_of(n));
            if (clr_at >= 0 && clr_at < exp_cyc[n]) exp_cyc[n] = clr_at + 1;
            got_cyc[n] = -1;
        end
        @(negedge Clk); add_valid = 1'b1; add_points = 4'(p);
        @(posedge Clk); #1; add_valid = 1'b0;
        check("ready_low0", add_ready0, 0);
        check("ready_low1", add_ready1, 0);
        for (int k = 0; k < 16; k++) begin
            frame_start = (k == fs_at);
            clear       = (k == clr_at);
            @(posedge Clk); #1;
            frame_start = 1'b0;
            clear       = 1'b0;
            #1;
            if (got_cyc[0] < 0 && add_ready0) got_cyc[0] = k + 1;
            if (got_cyc[1] < 0 && add_ready1) got_cyc[1] = k + 1;
            if (got_cyc[0] >= 0 && got_cyc[1] >= 0 && k >= fs_at && k >= clr_at) break;
        end
        check("add_cycles0", got_cyc[0], exp_cyc[0]);
        check("add_cycles1", got_cyc[1], exp_cyc[1]);
        for (int n = 0; n < 2; n++) begin
            if (clr_at >= 0) score_m[n] = 0;
            else score_m[n] = (score_m[n] + pc > max_of(n)) ? max_of(n) : score_m[n] + pc;
            if (fs_at >= 0) shadow_m[n] = score_m[n];
        end
    endtask

    task automatic check_idle_outputs(input string phase);
        check({phase, "_ready0"}, add_ready0, 1);
        check({phase, "_ready1"}, add_ready1, 1);
        check({phase, "_addr0"}, addr0, 0);
        check({phase, "_addr1"}, addr1, 0);
        check({phase, "_pix0"}, pix0, 0);
        check({phase, "_pix1"}, pix1, 0);
        check({phase, "_on0"}, on0, 0);
        check({phase, "_on1"}, on1, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; clear = 1'b0; add_valid = 1'b0;
        add_points = 4'd0; DrawX = 10'd0; DrawY = 10'd0; rom_mode = 0;
        for (int n = 0; n < 2; n++) begin score_m[n] = 0; shadow_m[n] = 0; end
        repeat (3) @(posedge Clk);
        @(negedge Clk); Reset_n = 1'b1; #1;
        check_idle_outputs("reset");

        // Empty score: every pixel transparent.
        stream(120);

        // 7 + 5 = 12, then the spot check on the units glyph.
        do_add(7, -1, -1);
        do_add(5, -1, -1);
        latch();
        display();
        begin
            int xs[$], ys[$];
            xs.push_back(448 + 5 * 32 + 3); ys.push_back(16 + 10);
            probe(xs, ys);
        end

        // Clear and add in the same cycle: clear wins, add is not taken.
        @(negedge Clk); clear = 1'b1; add_valid = 1'b1; add_points = 4'd5; #1;
        check("clr_add_ready0", add_ready0, 0);
        check("clr_add_ready1", add_ready1, 0);
        @(posedge Clk); #1; clear = 1'b0; add_valid = 1'b0; #1;
        check("clr_add_idle0", add_ready0, 1);
        check("clr_add_idle1", add_ready1, 1);
        for (int n = 0; n < 2; n++) score_m[n] = 0;
        latch();
        display();

        // 998 + 9: the three-digit instance saturates, the six-digit one carries.
        for (int i = 0; i < 110; i++) do_add(9, -1, -1);
        do_add(8, -1, -1);
        do_add(9, -1, -1);
        latch();
        display();

        // 999 + 1 with frame_start during the carry ripple.
        do_clear();
        for (int i = 0; i < 111; i++) do_add(9, -1, -1);
        latch();
        display();
        do_add(1, 1, -1);
        display();
        do_add(15, -1, -1);

        // Clear in the middle of a long carry chain.
        for (int i = 0; i < 110; i++) do_add(9, -1, -1);
        do_add(1, -1, 1);
        latch();
        display();

        // Random adds with occasional frame_start or clear during the add.
        for (int it = 0; it < 40; it++) begin
            int p  = int'($urandom_range(15));
            int r  = int'($urandom_range(9));
            int fs = -1;
            int cl = -1;
            if (r < 3) fs = int'($urandom_range(3));
            else if (r == 3) cl = int'($urandom_range(3));
            do_add(p, fs, cl);
            if (it % 8 == 7) begin
                latch();
                display();
            end
        end
        latch();
        rom_mode = 1;
        stream(150);

        // Reset in the middle of an add while the beam is inside both boxes.
        @(negedge Clk); add_valid = 1'b1; add_points = 4'd9;
        @(posedge Clk); #1; add_valid = 1'b0; DrawX = 10'd453; DrawY = 10'd20;
        @(negedge Clk); Reset_n = 1'b0;
        @(posedge Clk); #1;
        check_idle_outputs("mid_add_reset");
        @(negedge Clk);
        @(negedge Clk); Reset_n = 1'b1;
        for (int n = 0; n < 2; n++) begin score_m[n] = 0; shadow_m[n] = 0; end
        display();
        do_add(4, -1, -1);
        latch();
        display();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
